// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit-adjust threshold, and saturation constants.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] SAT_DIGIT     = 4'h9;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned bcd_max(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_max(4);
    localparam logic [15:0]     BCD_SAT = {4{SAT_DIGIT}};

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One decimal digit of the double-dabble adjust: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // digit_in <= 9 in normal operation, so +3 never exceeds 4 bits
    assign digit_out = (digit_in >= ADJ_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per clock.
// The published result is held until the next conversion completes.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam longint unsigned MAX_VAL = bcd_max(DIGITS);

    state_t             state_reg, state_next;
    logic [IN_W-1:0]    bin_reg, bin_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovr_reg, ovr_next;
    logic [BCD_W-1:0]   bcd_out_reg, bcd_out_next;
    logic               ovf_reg, ovf_next;
    logic               done_reg, done_next;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BCD_W-1:0]   sat_pattern;
    logic               in_over_range;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_in  (bcd_reg[gi*4 +: 4]),
            .digit_out (bcd_adj[gi*4 +: 4])
        );
        assign sat_pattern[gi*4 +: 4] = SAT_DIGIT;
    end

    assign bcd_shifted   = {bcd_adj[BCD_W-2:0], bin_reg[IN_W-1]};
    assign in_over_range = 64'(bin_in) > MAX_VAL;

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        bcd_next     = bcd_reg;
        cnt_next     = cnt_reg;
        ovr_next     = ovr_reg;
        bcd_out_next = bcd_out_reg;
        ovf_next     = ovf_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_next   = bin_in;
                    bcd_next   = '0;
                    cnt_next   = CNT_W'(IN_W);
                    ovr_next   = in_over_range;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                bin_next = {bin_reg[IN_W-2:0], 1'b0};
                bcd_next = bcd_shifted;
                cnt_next = cnt_reg - CNT_W'(1);
                // A bit shifted out of the accumulator can only mean over-range
                ovr_next = ovr_reg | bcd_adj[BCD_W-1];
                if (cnt_reg == CNT_W'(1)) begin
                    bcd_out_next = ovr_next ? sat_pattern : bcd_shifted;
                    ovf_next     = ovr_next;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            cnt_reg     <= '0;
            ovr_reg     <= 1'b0;
            bcd_out_reg <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            bcd_reg     <= bcd_next;
            cnt_reg     <= cnt_next;
            ovr_reg     <= ovr_next;
            bcd_out_reg <= bcd_out_next;
            ovf_reg     <= ovf_next;
            done_reg    <= done_next;
        end
    end

    assign busy    = (state_reg == CONVERT);
    assign done    = done_reg;
    assign bcd_out = bcd_out_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    localparam int IN_W = 14;
    localparam int LAT  = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal digits by division; saturate above 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          p;
        r = '0;
        if (v > 9999) return 16'h9999;
        p = 1;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // One full conversion; optionally pulses start mid-conversion with another value.
    task automatic run_conv(input int v, input int glitch_at, input int glitch_val);
        logic [15:0] prev_bcd;
        logic        prev_ovf;
        int          busy_cycles;
        @(negedge clk);
        prev_bcd = bcd_out;
        prev_ovf = ovf;
        start  = 1'b1;
        bin_in = 14'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cycles = 1;
        check_val("accept_busy", busy, 1);
        check_val("accept_done_low", done, 0);
        for (int i = 1; i < LAT; i++) begin
            if (i == glitch_at - 1) begin
                start  = 1'b1;
                bin_in = 14'(glitch_val);
            end else begin
                start  = 1'b0;
                bin_in = 14'($urandom_range(0, 16383));
            end
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            check_val("mid_done_low", done, 0);
            check_val("mid_bcd_hold", bcd_out, prev_bcd);
            check_val("mid_ovf_hold", ovf, prev_ovf);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("busy_len", busy_cycles, LAT);
        check_val("final_done", done, 1);
        check_val("final_busy", busy, 0);
        check_val("final_bcd", bcd_out, ref_bcd(v));
        check_val("final_ovf", ovf, (v > 9999) ? 1 : 0);
        $display("conv bin=%0d bcd=0x%04h ovf=%0b", v, bcd_out, ovf);
    endtask

    initial begin
        int vals [8] = '{0, 1234, 9999, 10000, 16383, 42, 9998, 10001};
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_bcd", bcd_out, 0);
        check_val("rst_ovf", ovf, 0);
        reset = 1'b0;

        foreach (vals[i]) run_conv(vals[i], 0, 0);

        // Start during a conversion is ignored and produces no extra done
        run_conv(500, 5, 77);
        @(posedge clk);
        #1;
        check_val("glitch_no_done", done, 0);
        check_val("glitch_idle", busy, 0);
        check_val("glitch_bcd", bcd_out, 16'h0500);

        // Start held high: back-to-back conversions every LAT+1 cycles
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd1;
        @(posedge clk);
        #1;
        check_val("held_accept", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            repeat (LAT) @(posedge clk);
            #1;
            check_val("held_done", done, 1);
            check_val("held_bcd", bcd_out, ref_bcd(k));
            $display("held bin=%0d bcd=0x%04h", k, bcd_out);
            bin_in = 14'(k + 1);
            if (k == 3) start = 1'b0;
            @(posedge clk);
            #1;
            check_val("held_done_clr", done, 0);
            check_val("held_rearm", busy, (k == 3) ? 0 : 1);
        end

        // Reset mid-conversion aborts
        run_conv(777, 0, 0);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_bcd", bcd_out, 0);
        check_val("abort_ovf", ovf, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("abort_no_done", done, 0);
        end
        $display("abort bcd=0x%04h ovf=%0b", bcd_out, ovf);
        run_conv(8, 0, 0);

        for (int n = 0; n < 25; n++) begin
            run_conv(int'($urandom_range(0, 16383)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the iterative shift-add-3 (double-dabble) method.
- Sits directly upstream of the 4-digit hex seven-segment driver. Its 16-bit packed-BCD output drives the driver's value input, so binary counts show as decimal digits.
- Holds the last result stable while a new conversion runs, so the display never shows partial values.
- Flags and saturates inputs that are out of range.

Parameters:
- IN_W, 14, width of the binary input; 14 bits covers 0..16383.
- DIGITS, 4, number of BCD digits. The output is 4*DIGITS bits, and the largest representable value is 10^DIGITS-1 (9999).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a conversion of bin_in; sampled only when busy=0
- bin_in  input  IN_W  unsigned binary value; captured on the edge that accepts start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd_out/ovf are updated
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0]; registered and held between conversions
- ovf  output  1  set with done when the captured value exceeded 10^DIGITS-1; held until the next done

Behaviour:
- Reset:
  - Synchronous, active-high, dominates all other inputs.
  - State=IDLE, busy=0, done=0, bcd_out=0, ovf=0.
  - Clears the internal shift register and step counter.
- States:
  - IDLE: start=1 at edge E0 captures bin_in into the binary shift register and clears the BCD accumulator.
    - Sets the step counter to IN_W and busy=1.
    - Also records the over-range compare (bin_in > 10^DIGITS-1) in a sticky bit.
    - Next state is CONVERT.
  - CONVERT: each edge performs one step, then decrements the counter.
    - Step part 1: every BCD digit >= 5 gets +3.
    - Step part 2: {bcd, bin} shifts left by 1, bringing the binary MSB into the BCD LSB.
    - On the step that makes the counter 0 (edge E0+IN_W), the following happen together:
      - bcd_out loads the final BCD result, or all digits = 9 if the over-range bit is set.
      - ovf loads the over-range bit.
      - done=1 and busy=0.
      - Next state is IDLE.
- Latency and throughput:
  - Latency is fixed at IN_W edges from acceptance to done, regardless of value or overflow.
  - done is high for exactly one cycle and clears on the next edge unless reset intervenes.
- start handling:
  - start while busy=1 is ignored; it is not queued.
  - start may be accepted on the edge where done is low again, i.e. during the done-high cycle (state IDLE).
  - start held continuously therefore converts every IN_W+1 cycles.
- bin_in changes after acceptance have no effect on the conversion in progress.
- bcd_out and ovf change only on a done edge or on reset. They are never visible mid-conversion.
- Width rules:
  - Each digit adjust is 4-bit; with the >=5 precondition, +3 cannot carry out.
  - The BCD accumulator is 4*DIGITS bits and no bit is lost before saturation applies.
- Reset mid-conversion aborts: no done is produced, and outputs take their reset values.
- The over-range compare uses the IN_W-bit input against the constant 10^DIGITS-1, zero-extended as needed.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - the state encoding (IDLE=0, CONVERT=1);
  - BCD_MAX = 10^DIGITS-1, the saturation pattern (all nibbles 4'h9), and the digit-adjust threshold 5.
- One sub-module, bcd_add3_digit: combinational, 4-bit in/out, adds 3 when in >= 5. Instantiated DIGITS times.

Test Plan:
- reset high 2 cycles, then start with bin_in=0 → done at E0+14, bcd_out=0x0000, ovf=0; busy high for exactly 14 cycles.
- bin_in=1234 → bcd_out=0x1234 at E0+14, ovf=0; bcd_out holds the previous value (0x0000) through the conversion.
- bin_in=9999 → 0x9999, ovf=0. Then bin_in=10000 → 0x9999, ovf=1. Then bin_in=16383 → 0x9999, ovf=1. Then bin_in=42 → 0x0042, ovf=0.
- start pulsed again at E0+5 with bin_in=77 during a conversion of 500 → ignored; result 0x0500, exactly one done.
- start held high with bin_in stepping 1,2,3 → done every 15 cycles, results 0x0001, 0x0002, 0x0003.
- reset asserted at E0+7 during a conversion of 4321 → no done; bcd_out=0, ovf=0, busy=0; next start with 8 → 0x0008.
